// File: rtl/cape_gpio_ctrl.sv
// APB-controlled GPIO bank for the cape header: per-pin out/oe, synchronised input, edge IRQ, blink override.
// Optional input debounce filter (register 0x24) is built when CAPE_GPIO_DEBOUNCE_EN is defined.
module cape_gpio_ctrl #(
    parameter int                  NUM_PINS = 28,
    parameter int                  BLINK_W  = 24,
    parameter logic [NUM_PINS-1:0] RESET_OE = '0
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [7:0]          paddr,
    input  logic [31:0]         pwdata,
    output logic [31:0]         prdata,
    output logic                pready,
    input  logic [NUM_PINS-1:0] gpio_in,
    output logic [NUM_PINS-1:0] gpio_out,
    output logic [NUM_PINS-1:0] gpio_oe,
    output logic                irq
);
    typedef logic [NUM_PINS-1:0] pins_t;

    localparam logic [5:0] A_OUT       = 6'h00;
    localparam logic [5:0] A_OE        = 6'h01;
    localparam logic [5:0] A_IN        = 6'h02;
    localparam logic [5:0] A_IRQ_EN    = 6'h03;
    localparam logic [5:0] A_IRQ_ST    = 6'h04;
    localparam logic [5:0] A_IRQ_EDGE  = 6'h05;
    localparam logic [5:0] A_BLINK_SEL = 6'h06;
    localparam logic [5:0] A_BLINK_PER = 6'h07;
    localparam logic [5:0] A_INFO      = 6'h08;
    localparam logic [5:0] A_DEBOUNCE  = 6'h09;
    localparam logic [7:0] NP8         = 8'(NUM_PINS);

    logic [5:0]         word;
    logic               wr;
    pins_t              wr_pins;
    pins_t              out_r, oe_r, irq_en, irq_status, irq_edge, blink_sel;
    logic [BLINK_W-1:0] blink_period, blink_cnt;
    logic               blink_phase;
    pins_t              sync1, sync2, filt, hist, edge_pulse, w1c;
    logic [31:0]        rd;
    logic               unused_ok;

    assign word      = paddr[7:2];
    assign wr        = psel & penable & pwrite;
    assign wr_pins   = pwdata[NUM_PINS-1:0];
    assign pready    = 1'b1;
    assign unused_ok = ^{paddr[1:0], pwdata};

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;
        end
    end

`ifdef CAPE_GPIO_DEBOUNCE_EN
    logic [15:0]                debounce;
    logic [NUM_PINS-1:0][15:0] db_cnt;

    always_ff @(posedge PCLK) begin
        if (PRESET)
            debounce <= '0;
        else if (wr && word == A_DEBOUNCE)
            debounce <= pwdata[15:0];
    end

    // Filtered value follows sync2 only after DEBOUNCE+1 consecutive differing cycles.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            db_cnt <= '0;
            filt   <= '0;
        end else begin
            for (int i = 0; i < NUM_PINS; i++) begin
                if (sync2[i] != filt[i]) begin
                    if (db_cnt[i] == debounce) begin
                        filt[i]   <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 16'd1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end
`else
    assign filt = sync2;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) hist <= '0;
        else        hist <= filt;
    end

    assign edge_pulse = (irq_edge & ~filt & hist) | (~irq_edge & filt & ~hist);
    assign w1c        = (wr && word == A_IRQ_ST) ? wr_pins : '0;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            out_r        <= '0;
            oe_r         <= RESET_OE;
            irq_en       <= '0;
            irq_status   <= '0;
            irq_edge     <= '0;
            blink_sel    <= '0;
            blink_period <= '0;
        end else begin
            // A new edge wins over a simultaneous clear of the same bit.
            irq_status <= (irq_status & ~w1c) | edge_pulse;
            if (wr) begin
                case (word)
                    A_OUT:       out_r        <= wr_pins;
                    A_OE:        oe_r         <= wr_pins;
                    A_IRQ_EN:    irq_en       <= wr_pins;
                    A_IRQ_EDGE:  irq_edge     <= wr_pins;
                    A_BLINK_SEL: blink_sel    <= wr_pins;
                    A_BLINK_PER: blink_period <= pwdata[BLINK_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET || (wr && word == A_BLINK_PER) || blink_period == '0) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == blink_period) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            gpio_out <= '0;
            gpio_oe  <= RESET_OE;
            irq      <= 1'b0;
        end else begin
            gpio_out <= (out_r & ~blink_sel) | (blink_sel & {NUM_PINS{blink_phase}});
            gpio_oe  <= oe_r | blink_sel;
            irq      <= |(irq_status & irq_en);
        end
    end

    always_comb begin
        rd = '0;
        case (word)
            A_OUT:       rd[NUM_PINS-1:0] = out_r;
            A_OE:        rd[NUM_PINS-1:0] = oe_r;
            A_IN:        rd[NUM_PINS-1:0] = filt;
            A_IRQ_EN:    rd[NUM_PINS-1:0] = irq_en;
            A_IRQ_ST:    rd[NUM_PINS-1:0] = irq_status;
            A_IRQ_EDGE:  rd[NUM_PINS-1:0] = irq_edge;
            A_BLINK_SEL: rd[NUM_PINS-1:0] = blink_sel;
            A_BLINK_PER: rd[BLINK_W-1:0]  = blink_period;
            A_INFO:      rd = {16'h0C47, 8'h00, NP8};
`ifdef CAPE_GPIO_DEBOUNCE_EN
            A_DEBOUNCE:  rd[15:0] = debounce;
`endif
            default: ;
        endcase
    end

    assign prdata = (psel && !pwrite && !PRESET) ? rd : '0;

endmodule

// File: tb/tb_cape_gpio_ctrl.sv
// Directed self-checking bench for cape_gpio_ctrl (default parameters, debounce disabled).
module tb_cape_gpio_ctrl;
    localparam int NP = 28;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          psel, penable, pwrite;
    logic [7:0]    paddr;
    logic [31:0]   pwdata, prdata;
    logic          pready;
    logic [NP-1:0] gpio_in, gpio_out, gpio_oe;
    logic          irq;
    logic [31:0]   rd;
    int            total = 0;
    int            bad   = 0;

    always #5 PCLK = ~PCLK;

    cape_gpio_ctrl dut (
        .PCLK(PCLK), .PRESET(PRESET), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    task automatic step(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Returns 1 ns after the write edge.
    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        @(posedge PCLK); #1;
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(posedge PCLK); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        @(posedge PCLK); #1;
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
        @(posedge PCLK); #1;
        penable = 1'b1;
        d = prdata;
        @(posedge PCLK); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        PRESET = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; gpio_in = '0;
        step(3);
        chk("rst_oe", 32'(gpio_oe), 32'h0);
        chk("rst_out", 32'(gpio_out), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_prdata", prdata, 32'h0);
        chk("pready", 32'(pready), 32'h1);
        PRESET = 1'b0;

        for (int a = 0; a <= 9; a++) begin
            apb_read(8'(a * 4), rd);
            chk("rst_read", rd, (a == 8) ? 32'h0C47001C : 32'h0);
        end

        // OUT / OE registers, registered pad outputs
        apb_write(8'h00, 32'h5);
        chk("out_lat0", 32'(gpio_out), 32'h0);
        step(1);
        chk("out_lat1", 32'(gpio_out), 32'h5);
        apb_write(8'h04, 32'hF);
        step(1);
        chk("oe", 32'(gpio_oe), 32'hF);
        apb_write(8'h00, 32'hFFFF_FFFF);
        apb_read(8'h00, rd);
        chk("out_mask", rd, 32'h0FFF_FFFF);
        apb_write(8'h00, 32'h0);

        // Rising edge on pin 3: status 3 cycles after the pad, irq one later
        apb_write(8'h0C, 32'h8);
        apb_write(8'h14, 32'h0);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = 8'h10;
        gpio_in[3] = 1'b1;
        step(1);
        chk("st_c1", prdata, 32'h0);
        step(1);
        chk("st_c2", prdata, 32'h0);
        step(1);
        chk("st_c3", prdata, 32'h8);
        chk("irq_c3", 32'(irq), 32'h0);
        step(1);
        chk("irq_c4", 32'(irq), 32'h1);
        psel = 1'b0;
        apb_read(8'h08, rd);
        chk("in_reg", rd, 32'h8);

        apb_write(8'h10, 32'h8);
        chk("irq_hold", 32'(irq), 32'h1);
        step(1);
        chk("irq_clr", 32'(irq), 32'h0);
        apb_read(8'h10, rd);
        chk("st_clr", rd, 32'h0);

        // Clear lands on the same edge as a new rising edge: set wins
        gpio_in[3] = 1'b0;
        step(4);
        gpio_in[3] = 1'b1;
        step(1);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 8'h10; pwdata = 32'h8;
        step(1);
        penable = 1'b1;
        step(1);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        apb_read(8'h10, rd);
        chk("set_wins", rd, 32'h8);
        apb_write(8'h10, 32'h8);
        apb_read(8'h10, rd);
        chk("st_clr2", rd, 32'h0);

        // Falling-edge polarity
        apb_write(8'h14, 32'h8);
        gpio_in[3] = 1'b0;
        step(5);
        apb_read(8'h10, rd);
        chk("fall_edge", rd, 32'h8);
        apb_write(8'h10, 32'h8);
        apb_write(8'h0C, 32'h0);
        apb_read(8'h10, rd);
        chk("st_clr3", rd, 32'h0);
        step(1);
        chk("irq_off", 32'(irq), 32'h0);

        // Blink on pin 5, half-period 4 cycles
        apb_write(8'h18, 32'h20);
        apb_write(8'h1C, 32'h3);
        chk("blink_oe", 32'(gpio_oe), 32'h2F);
        for (int k = 0; k <= 16; k++) begin
            chk("blink", 32'(gpio_out), (k != 0 && ((k - 1) / 4) % 2 == 1) ? 32'h20 : 32'h0);
            step(1);
        end
        apb_write(8'h1C, 32'h0);
        step(1);
        for (int k = 0; k < 8; k++) begin
            chk("blink_off", 32'(gpio_out), 32'h0);
            step(1);
        end

        // Reset during the access phase of an OUT write
        apb_write(8'h1C, 32'h3);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 8'h00; pwdata = 32'h123;
        step(1);
        penable = 1'b1; PRESET = 1'b1;
        step(1);
        PRESET = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        chk("rst2_oe", 32'(gpio_oe), 32'h0);
        chk("rst2_out", 32'(gpio_out), 32'h0);
        chk("rst2_irq", 32'(irq), 32'h0);
        apb_read(8'h00, rd);
        chk("rst2_outreg", rd, 32'h0);
        apb_read(8'h1C, rd);
        chk("rst2_period", rd, 32'h0);
        apb_read(8'h04, rd);
        chk("rst2_oereg", rd, 32'h0);

        apb_write(8'h18, 32'h20);
        apb_write(8'h1C, 32'h3);
        chk("blink2_oe", 32'(gpio_oe), 32'h20);
        for (int k = 0; k <= 9; k++) begin
            chk("blink2", 32'(gpio_out), (k != 0 && ((k - 1) / 4) % 2 == 1) ? 32'h20 : 32'h0);
            step(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cape_gpio_ctrl.md
Name: cape_gpio_ctrl

Overview:
APB-controlled GPIO bank for the cape header. It succeeds the fixed control/status register and hard-wired blinky pin with a parametrised block that provides the following per pin:
- output and output-enable registers;
- a synchronised input;
- an edge interrupt;
- a blink override.

It sits between the APB slave port and the header IOPAD wrappers. It drives GPIO_OUT/GPIO_OE and an aggregated interrupt line into the INT_x vectors.

Parameters:
NUM_PINS, 28, number of GPIO pins handled (1..32).
BLINK_W, 24, width of blink half-period counter and BLINK_PERIOD register.
RESET_OE, 0, reset value of the OE register (bit per pin).

Ports:
PCLK  in  1  clock; all logic on rising edge.
PRESET  in  1  synchronous, active-high reset.
psel  in  1  APB select.
penable  in  1  APB enable.
pwrite  in  1  APB write.
paddr  in  8  APB byte address (bits [1:0] ignored).
pwdata  in  32  APB write data.
prdata  out  32  APB read data.
pready  out  1  tied 1 (zero wait state).
gpio_in  in  NUM_PINS  raw pad inputs (asynchronous).
gpio_out  out  NUM_PINS  pad output values.
gpio_oe  out  NUM_PINS  pad output enables.
irq  out  1  OR of (IRQ_STATUS & IRQ_EN), registered.

Behaviour:
- Reset (PRESET=1 at a clock edge) sets:
  - all registers to 0, except OE = RESET_OE;
  - synchronisers to 0;
  - blink counter and phase to 0;
  - irq = 0 and prdata = 0.
- APB write takes effect on the edge where psel & penable & pwrite; new value is visible the next cycle.
- APB read: prdata is a combinational mux when psel & !pwrite, otherwise 0. Unmapped addresses read 0; writes to them are ignored. Bits at or above NUM_PINS read 0 and ignore writes.
- Register map:
  - 0x00 OUT: rw.
  - 0x04 OE: rw.
  - 0x08 IN: ro, synchronised input.
  - 0x0C IRQ_EN: rw.
  - 0x10 IRQ_STATUS: write-1-to-clear.
  - 0x14 IRQ_EDGE: rw; per pin, 0 = rising, 1 = falling.
  - 0x18 BLINK_SEL: rw.
  - 0x1C BLINK_PERIOD: rw, BLINK_W bits.
  - 0x20 INFO: ro, returns {16'h0C47, 8'h00, NUM_PINS[7:0]}.
- Input path:
  - 2-flop synchroniser, then one history flop.
  - IN reflects the pad 2 cycles after a stable change.
  - The edge pulse (sync vs history, per IRQ_EDGE polarity) sets the IRQ_STATUS bit 3 cycles after the pad change.
- IRQ_STATUS bits set regardless of IRQ_EN; IRQ_EN only gates irq.
- Simultaneous W1C and new edge on the same bit: set wins, bit stays 1.
- irq is registered: asserts 1 cycle after a status bit becomes set while enabled. It deasserts 1 cycle after the clear, or after the IRQ_EN bit drops.
- Blink generator:
  - Counter increments each cycle.
  - When counter == BLINK_PERIOD, the counter returns to 0 and the blink phase toggles.
  - Full period is therefore 2*(BLINK_PERIOD+1) cycles.
  - BLINK_PERIOD = 0 holds counter and phase at 0 (no blinking).
  - Any write to BLINK_PERIOD clears counter and phase in the same edge.
  - Counter wraps only via the compare, never by overflow.
- Output mux: gpio_out[i] = BLINK_SEL[i] ? phase : OUT[i], registered, so 1 cycle after the register/phase change.
- gpio_oe[i] = OE[i] | BLINK_SEL[i], registered.
- Reset asserted mid-transfer aborts the write; no register changes on that edge.

Optional Feature:
Macro CAPE_GPIO_DEBOUNCE_EN.
- Defined:
  - Adds register 0x24 DEBOUNCE (16 bits, reset 0).
  - Each pin gets a 16-bit stability counter after the synchroniser.
  - The filtered value updates only after the synchronised input differs from it for DEBOUNCE+1 consecutive cycles; the counter resets on any bounce.
  - DEBOUNCE = 0 gives a 1-cycle filter latency.
  - IN and edge detection use the filtered value.
- Undefined: 0x24 is unmapped (reads 0) and timing is as above.

Test Plan:
- Reset with RESET_OE=0, then read 0x00..0x20 -> all read 0 except INFO = 0x0C47001C; gpio_oe=0, irq=0.
- Write OUT=0x5, OE=0xF -> gpio_out=0x5 and gpio_oe=0xF one cycle after the write's access phase; write 0xFFFFFFFF to OUT -> reads 0x0FFFFFFF.
- IRQ_EN[3]=1, IRQ_EDGE[3]=0, drive gpio_in[3] 0->1 -> IRQ_STATUS=0x8 three cycles later and irq=1 one cycle after that. W1C 0x8 -> irq=0 next cycle. Fire a new edge in the same cycle as the clear -> status stays 0x8.
- BLINK_SEL=0x20, BLINK_PERIOD=3 -> gpio_out[5] toggles every 4 cycles (period 8) and gpio_oe[5]=1. BLINK_PERIOD=0 -> gpio_out[5] holds 0.
- Assert PRESET during the access phase of a write to OUT -> OUT stays 0; the blink counter restarts from 0 after release.
- With CAPE_GPIO_DEBOUNCE_EN and DEBOUNCE=4: a 3-cycle glitch on gpio_in[0] leaves IN unchanged and no IRQ; a stable level is seen 2+5 cycles after the change.
